// File: rtl/fft32_pkg.sv
// Shared FFT32 constants, the complex sample type and the 5-bit bit-reversal helper.
package fft32_pkg;

  localparam int DW   = 32;
  localparam int N    = 32;
  localparam int IDXW = 5;
  localparam int CNTW = 16;

  typedef struct packed {
    logic [DW-1:0] r;
    logic [DW-1:0] i;
  } cplx_t;

  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_HOLD = 1'b1
  } ld_state_t;

  function automatic logic [IDXW-1:0] bitrev5(input logic [IDXW-1:0] idx);
    logic [IDXW-1:0] rev;
    rev = {IDXW{1'b0}};
    for (int b = 0; b < IDXW; b++) begin
      rev[b] = idx[IDXW-1-b];
    end
    return rev;
  endfunction

endpackage

// File: rtl/fft32_frame_loader_if.sv
// Serial sample input and parallel frame output handshakes of the FFT32 frame loader.
interface fft32_frame_loader_if;
  import fft32_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_r;
  logic [DW-1:0]   in_i;
  logic            in_last;
  logic            out_valid;
  logic            out_ready;
  logic [N*DW-1:0] out_r;
  logic [N*DW-1:0] out_i;

  modport master (
    output in_valid, in_r, in_i, in_last, out_ready,
    input  in_ready, out_valid, out_r, out_i
  );

  modport slave (
    input  in_valid, in_r, in_i, in_last, out_ready,
    output in_ready, out_valid, out_r, out_i
  );

endinterface

// File: rtl/fft32_frame_bank.sv
// 32-slot complex register bank: one indexed write port, whole bank read in parallel.
module fft32_frame_bank
  import fft32_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            i_we,
  input  logic [IDXW-1:0] i_idx,
  input  cplx_t           i_data,
  output logic [N*DW-1:0] o_r,
  output logic [N*DW-1:0] o_i
);

  logic [N*DW-1:0] r_r;
  logic [N*DW-1:0] r_i;

  // Slot storage, cleared on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_r <= {(N*DW){1'b0}};
      r_i <= {(N*DW){1'b0}};
    end else if (i_we) begin
      r_r[DW*i_idx +: DW] <= i_data.r;
      r_i[DW*i_idx +: DW] <= i_data.i;
    end
  end

  assign o_r = r_r;
  assign o_i = r_i;

endmodule

// File: rtl/fft32_frame_loader.sv
// Serial-to-parallel frame loader feeding the 32-point FFT butterfly network.
// Build option FFT32_LOADER_PINGPONG_EN: two banks so filling continues while a frame is held.
module fft32_frame_loader
  import fft32_pkg::*;
#(
  parameter bit BIT_REV = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  fft32_frame_loader_if.slave bus,
  output logic                frame_err,
  output logic [CNTW-1:0]     frame_cnt
);

  logic [IDXW-1:0] r_wr_idx;
  logic            r_in_ready;
  logic            r_out_valid;
  logic            r_frame_err;
  logic [CNTW-1:0] r_frame_cnt;

  logic            w_xfer;
  logic            w_last_slot;
  logic            w_early;
  logic            w_we;
  logic            w_done;
  logic            w_pop;
  logic [IDXW-1:0] w_slot;
  cplx_t           w_sample;
  logic [N*DW-1:0] w_out_r;
  logic [N*DW-1:0] w_out_i;

  assign w_xfer      = bus.in_valid & r_in_ready;
  assign w_last_slot = (r_wr_idx == 5'd31);
  // in_last only aborts before the final slot; on slot 31 the frame completes regardless
  assign w_early     = w_xfer & bus.in_last & ~w_last_slot;
  assign w_we        = w_xfer & ~w_early;
  assign w_done      = w_we & w_last_slot;
  assign w_pop       = r_out_valid & bus.out_ready;
  assign w_slot      = BIT_REV ? bitrev5(r_wr_idx) : r_wr_idx;
  assign w_sample    = {bus.in_r, bus.in_i};

  // Write index, abort pulse and delivered-frame counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_idx    <= 5'd0;
      r_frame_err <= 1'b0;
      r_frame_cnt <= 16'd0;
    end else begin
      r_frame_err <= w_early;
      if (w_early || w_done) begin
        r_wr_idx <= 5'd0;
      end else if (w_we) begin
        r_wr_idx <= r_wr_idx + 5'd1;
      end
      if (w_pop) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
    end
  end

`ifdef FFT32_LOADER_PINGPONG_EN
  logic [1:0]      r_full;
  logic            r_wr_bank;
  logic            r_rd_bank;
  logic [1:0]      w_full_n;
  logic            w_wr_bank_n;
  logic            w_rd_bank_n;
  logic [N*DW-1:0] w_a_r, w_a_i, w_b_r, w_b_i;

  // Next bank occupancy: a pop frees the oldest bank, a completion fills the write bank
  always_comb begin
    w_full_n    = r_full;
    w_wr_bank_n = r_wr_bank;
    w_rd_bank_n = r_rd_bank;
    if (w_pop) begin
      w_full_n[r_rd_bank] = 1'b0;
      w_rd_bank_n         = ~r_rd_bank;
    end else begin
      w_rd_bank_n = r_rd_bank;
    end
    if (w_done) begin
      w_full_n[r_wr_bank] = 1'b1;
      w_wr_bank_n         = ~r_wr_bank;
    end else begin
      w_wr_bank_n = r_wr_bank;
    end
  end

  // Bank pointers and registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_full      <= 2'b00;
      r_wr_bank   <= 1'b0;
      r_rd_bank   <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_full      <= w_full_n;
      r_wr_bank   <= w_wr_bank_n;
      r_rd_bank   <= w_rd_bank_n;
      r_in_ready  <= ~(&w_full_n);
      r_out_valid <= w_full_n[w_rd_bank_n];
    end
  end

  fft32_frame_bank u_bank_a (
    .clk(clk), .rst(rst), .i_we(w_we & ~r_wr_bank), .i_idx(w_slot),
    .i_data(w_sample), .o_r(w_a_r), .o_i(w_a_i)
  );

  fft32_frame_bank u_bank_b (
    .clk(clk), .rst(rst), .i_we(w_we & r_wr_bank), .i_idx(w_slot),
    .i_data(w_sample), .o_r(w_b_r), .o_i(w_b_i)
  );

  assign w_out_r = r_rd_bank ? w_b_r : w_a_r;
  assign w_out_i = r_rd_bank ? w_b_i : w_a_i;
`else
  ld_state_t r_state;

  // FILL/HOLD control with registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_FILL;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_FILL: begin
          if (w_done) begin
            r_state     <= ST_HOLD;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (w_pop) begin
            r_state     <= ST_FILL;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_FILL;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  fft32_frame_bank u_bank (
    .clk(clk), .rst(rst), .i_we(w_we), .i_idx(w_slot),
    .i_data(w_sample), .o_r(w_out_r), .o_i(w_out_i)
  );
`endif

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_r     = w_out_r;
  assign bus.out_i     = w_out_i;
  assign frame_err     = r_frame_err;
  assign frame_cnt     = r_frame_cnt;

endmodule

// File: tb/tb_fft32_frame_loader.sv
// Bench for fft32_frame_loader: natural and bit-reversed instances share stimulus
// and are checked every cycle against a frame-queue reference model.
module tb_fft32_frame_loader;

  localparam int W  = 32;
  localparam int NS = 32;
`ifdef FFT32_LOADER_PINGPONG_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  typedef struct {
    logic [W-1:0] r [NS];
    logic [W-1:0] i [NS];
  } frame_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        err0, err1;
  logic [15:0] cnt0, cnt1;

  fft32_frame_loader_if ifa();
  fft32_frame_loader_if ifb();

  fft32_frame_loader #(.BIT_REV(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .bus(ifa), .frame_err(err0), .frame_cnt(cnt0)
  );

  fft32_frame_loader #(.BIT_REV(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .bus(ifb), .frame_err(err1), .frame_cnt(cnt1)
  );

  always #5 clk = ~clk;

  int          n_asserts = 0;
  int          n_fail    = 0;
  frame_t      q[$];
  frame_t      cur;
  int          cur_n = 0;
  logic        m_rdy = 1'b1;
  logic        m_vld = 1'b0;
  logic        m_err = 1'b0;
  logic [15:0] m_cnt = 16'd0;

  function automatic int rev5(input int k);
    return ((k & 1) << 4) | ((k & 2) << 2) | (k & 4) | ((k & 8) >> 2) | ((k & 16) >> 4);
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("in_ready0", 32'(ifa.in_ready), 32'(m_rdy));
    chk("in_ready1", 32'(ifb.in_ready), 32'(m_rdy));
    chk("out_valid0", 32'(ifa.out_valid), 32'(m_vld));
    chk("out_valid1", 32'(ifb.out_valid), 32'(m_vld));
    chk("frame_err0", 32'(err0), 32'(m_err));
    chk("frame_err1", 32'(err1), 32'(m_err));
    chk("frame_cnt0", 32'(cnt0), 32'(m_cnt));
    chk("frame_cnt1", 32'(cnt1), 32'(m_cnt));
    if (m_vld) begin
      for (int k = 0; k < NS; k++) begin
        chk($sformatf("nat_r[%0d]", k), ifa.out_r[k*W +: W], q[0].r[k]);
        chk($sformatf("nat_i[%0d]", k), ifa.out_i[k*W +: W], q[0].i[k]);
        chk($sformatf("rev_r[%0d]", k), ifb.out_r[k*W +: W], q[0].r[rev5(k)]);
        chk($sformatf("rev_i[%0d]", k), ifb.out_i[k*W +: W], q[0].i[rev5(k)]);
      end
    end
  endtask

  task automatic chk_zero(input string tag);
    for (int k = 0; k < NS; k++) begin
      chk($sformatf("%s_nat_r[%0d]", tag, k), ifa.out_r[k*W +: W], 32'd0);
      chk($sformatf("%s_nat_i[%0d]", tag, k), ifa.out_i[k*W +: W], 32'd0);
      chk($sformatf("%s_rev_r[%0d]", tag, k), ifb.out_r[k*W +: W], 32'd0);
      chk($sformatf("%s_rev_i[%0d]", tag, k), ifb.out_i[k*W +: W], 32'd0);
    end
  endtask

  // One clock: drive inputs, advance the model across the edge, compare just after it.
  task automatic step(input logic v, input logic [W-1:0] sr, input logic [W-1:0] si,
                      input logic last, input logic ordy, input logic rs);
    logic acc, pop;
    rst = rs;
    ifa.in_valid = v; ifa.in_r = sr; ifa.in_i = si; ifa.in_last = last; ifa.out_ready = ordy;
    ifb.in_valid = v; ifb.in_r = sr; ifb.in_i = si; ifb.in_last = last; ifb.out_ready = ordy;
    @(posedge clk);
    if (rs) begin
      q.delete();
      cur_n = 0;
      m_cnt = 16'd0;
      m_err = 1'b0;
    end else begin
      acc   = v & m_rdy;
      pop   = m_vld & ordy;
      m_err = 1'b0;
      if (pop) begin
        void'(q.pop_front());
        m_cnt = m_cnt + 16'd1;
      end
      if (acc) begin
        if (last && cur_n < NS - 1) begin
          cur_n = 0;
          m_err = 1'b1;
        end else begin
          cur.r[cur_n] = sr;
          cur.i[cur_n] = si;
          cur_n++;
          if (cur_n == NS) begin
            q.push_back(cur);
            cur_n = 0;
          end
        end
      end
    end
    m_rdy = (q.size() < CAP);
    m_vld = (q.size() > 0);
    #1;
    check_all();
  endtask

  // Offer one sample until the model says it was accepted, with a bounded wait.
  task automatic send(input logic [W-1:0] sr, input logic [W-1:0] si,
                      input logic last, input logic ordy);
    logic done;
    done = 1'b0;
    for (int t = 0; t < 200 && !done; t++) begin
      done = m_rdy;
      step(1'b1, sr, si, last, ordy, 1'b0);
    end
    chk("send_accepted", 32'(done), 32'd1);
  endtask

  initial begin
    // Reset state
    step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    chk_zero("reset");

    // Ramp frame (n, 100+n), held for 50 cycles with out_ready low
    for (int n = 0; n < NS; n++) send(32'(n), 32'(100 + n), (n == NS - 1), 1'b0);
    chk("nat_slot5_r", ifa.out_r[5*W +: W], 32'd5);
    chk("rev_slot1_r", ifb.out_r[1*W +: W], 32'd16);
    chk("rev_slot1_i", ifb.out_i[1*W +: W], 32'd116);
    chk("rev_slot3_r", ifb.out_r[3*W +: W], 32'd24);
    chk("rev_slot3_i", ifb.out_i[3*W +: W], 32'd124);
    chk("rev_slot31_r", ifb.out_r[31*W +: W], 32'd31);
    chk("rev_slot31_i", ifb.out_i[31*W +: W], 32'd131);
    repeat (50) step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);

    // Early in_last on sample 9, then a clean random frame
    for (int n = 0; n < 10; n++) send(32'(200 + n), 32'(300 + n), (n == 9), 1'b0);
    step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    for (int n = 0; n < NS; n++) send($urandom, $urandom, 1'b0, 1'b0);
    step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);

    // Random traffic: gaps, back-pressure, occasional early in_last
    for (int c = 0; c < 800; c++) begin
      step(($urandom_range(0, 3) != 0), $urandom, $urandom,
           (cur_n == NS - 1) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 30) == 0),
           ($urandom_range(0, 2) != 0), 1'b0);
    end

    // Reset mid-frame and while a frame is held
    step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    chk_zero("rst_idle");
    for (int n = 0; n < 20; n++) send($urandom, $urandom, 1'b0, 1'b0);
    step(1'b1, 32'd7, 32'd7, 1'b0, 1'b0, 1'b1);
    chk_zero("rst_partial");
    for (int n = 0; n < NS; n++) send($urandom, $urandom, (n == NS - 1), 1'b0);
    repeat (3) step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1);
    chk_zero("rst_hold");
    for (int n = 0; n < NS; n++) send(32'(500 + n), 32'(600 + n), (n == NS - 1), 1'b0);
    step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);

    // 96 continuous samples with out_ready held high
    for (int n = 0; n < 3 * NS; n++) send(32'(1000 + n), 32'(2000 + n), ((n % NS) == NS - 1), 1'b1);
    repeat (4) step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);

    // Fill every bank with out_ready low, keep offering, then drain
    for (int n = 0; n < CAP * NS; n++) send($urandom, $urandom, 1'b0, 1'b0);
    repeat (5) step(1'b1, $urandom, $urandom, 1'b0, 1'b0, 1'b0);
    repeat (CAP + 2) step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    chk("final_cnt", 32'(cnt0), 32'(m_cnt));

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
